// File: rtl/pc_redirect_unit.sv
// Fetch PC register with sequential/branch update, CSR flush/return and prioritised
// masked interrupts; a redirect raised under stall is held in a slot until the stall clears.
module pc_redirect_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     NUM_IRQ   = 4,
  parameter bit              VECTORED  = 1'b1,
  parameter int unsigned     IALIGN    = 4,
  localparam int unsigned    CW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write_en,
  input  logic [XLEN-1:0]    pc_in,
  input  logic               im_stall,
  input  logic               dm_stall,
  input  logic               csr_stall,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic [XLEN-1:0]    csr_tvec_base,
  input  logic               csr_ret,
  input  logic [XLEN-1:0]    csr_retpc,
  input  logic               csr_flush,
  output logic [XLEN-1:0]    pc_out,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [CW-1:0]      irq_cause,
  output logic               redirect_pend,
  output logic               misalign_err
);

  localparam int unsigned LSB = (IALIGN == 2) ? 1 : 2;

  typedef enum logic {ST_RUN = 1'b0, ST_PEND = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    slot_q, slot_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic [CW-1:0]      cause_q, cause_d;
  logic               mis_q, mis_d;

  logic               stall;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] avail;
  logic               sel_valid;
  logic [CW-1:0]      sel_idx;
  logic [NUM_IRQ-1:0] sel_onehot;
  logic [NUM_IRQ-1:0] take;
  logic [XLEN-1:0]    base_al;
  logic [XLEN-1:0]    target;
  logic [XLEN-1:0]    pc_aligned;
  logic               misaligned;

  assign stall      = im_stall | dm_stall | csr_stall;
  assign rise       = irq & ~irq_q & irq_mask;
  assign avail      = pend_q & irq_mask;
  assign base_al    = {csr_tvec_base[XLEN-1:2], 2'b00};
  assign target     = VECTORED ? (base_al + ({{(XLEN-CW){1'b0}}, sel_idx} << 2)) : base_al;
  assign pc_aligned = {pc_in[XLEN-1:LSB], {LSB{1'b0}}};
  assign misaligned = |pc_in[LSB-1:0];

  // Lowest-numbered enabled pending line wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (avail[i]) begin
        sel_valid = 1'b1;
        sel_idx   = CW'(i);
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      sel_onehot[i] = sel_valid && (sel_idx == CW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (!csr_flush && (csr_ret || sel_valid) && stall) state_d = ST_PEND;
      ST_PEND: if (csr_flush || !stall) state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    slot_d  = slot_q;
    ack_d   = '0;
    cause_d = cause_q;
    mis_d   = 1'b0;
    take    = '0;
    case (state_q)
      ST_RUN: begin
        if (csr_flush) begin
          pc_d = RESET_VEC;
        end else if (csr_ret) begin
          if (stall) slot_d = csr_retpc;
          else       pc_d   = csr_retpc;
        end else if (sel_valid) begin
          take    = sel_onehot;
          ack_d   = sel_onehot;
          cause_d = sel_idx;
          if (stall) slot_d = target;
          else       pc_d   = target;
        end else if (write_en && !stall) begin
          pc_d  = pc_aligned;
          mis_d = misaligned;
        end
      end
      ST_PEND: begin
        if (csr_flush) begin
          pc_d = RESET_VEC;
        end else begin
          // A return arriving in the release cycle is the newest redirect, so it is applied directly.
          if (csr_ret) slot_d = csr_retpc;
          if (!stall)  pc_d   = csr_ret ? csr_retpc : slot_q;
        end
      end
    endcase
  end

  assign pend_d = (pend_q & ~take) | rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VEC;
      slot_q  <= '0;
      irq_q   <= '0;
      pend_q  <= '0;
      ack_q   <= '0;
      cause_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      slot_q  <= slot_d;
      irq_q   <= irq;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      cause_q <= cause_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_out        = pc_q;
  assign irq_ack       = ack_q;
  assign irq_cause     = cause_q;
  assign redirect_pend = (state_q == ST_PEND);
  assign misalign_err  = mis_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed vector table, corner-case sequences and a random
// phase checked against a cycle-level behavioural model.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic [31:0] pc_in;
  logic        im_stall, dm_stall, csr_stall;
  logic [3:0]  irq, irq_mask;
  logic [31:0] csr_tvec_base;
  logic        csr_ret;
  logic [31:0] csr_retpc;
  logic        csr_flush;
  logic [31:0] pc_out;
  logic [3:0]  irq_ack;
  logic [1:0]  irq_cause;
  logic        redirect_pend;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  pc_redirect_unit dut (
    .clk(clk), .reset(reset), .write_en(write_en), .pc_in(pc_in),
    .im_stall(im_stall), .dm_stall(dm_stall), .csr_stall(csr_stall),
    .irq(irq), .irq_mask(irq_mask), .csr_tvec_base(csr_tvec_base),
    .csr_ret(csr_ret), .csr_retpc(csr_retpc), .csr_flush(csr_flush),
    .pc_out(pc_out), .irq_ack(irq_ack), .irq_cause(irq_cause),
    .redirect_pend(redirect_pend), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_pc, m_slot;
  bit          m_pst;
  bit          m_pend[4];
  bit          m_prev[4];
  logic [3:0]  m_ack;
  int          m_cause;
  bit          m_mis;

  task automatic model_edge();
    int sel;
    bit st;
    bit rise[4];
    logic [31:0] tgt;
    if (reset) begin
      m_pc = 0; m_slot = 0; m_pst = 0; m_ack = 0; m_cause = 0; m_mis = 0;
      for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
    end else begin
      st = im_stall || dm_stall || csr_stall;
      m_ack = 0;
      m_mis = 0;
      sel = -1;
      for (int i = 0; i < 4; i++) if (sel < 0 && m_pend[i] && irq_mask[i]) sel = i;
      for (int i = 0; i < 4; i++) rise[i] = irq[i] && !m_prev[i] && irq_mask[i];
      if (!m_pst) begin
        if (csr_flush) m_pc = 0;
        else if (csr_ret) begin
          if (st) begin m_slot = csr_retpc; m_pst = 1; end
          else m_pc = csr_retpc;
        end else if (sel >= 0) begin
          tgt = (csr_tvec_base & 32'hFFFF_FFFC) + 32'(4 * sel);
          m_ack[sel] = 1'b1;
          m_cause = sel;
          m_pend[sel] = 0;
          if (st) begin m_slot = tgt; m_pst = 1; end
          else m_pc = tgt;
        end else if (write_en && !st) begin
          m_pc  = pc_in & 32'hFFFF_FFFC;
          m_mis = (pc_in % 4) != 0;
        end
      end else begin
        if (csr_flush) begin m_pc = 0; m_pst = 0; end
        else begin
          if (csr_ret) m_slot = csr_retpc;
          if (!st) begin m_pc = m_slot; m_pst = 0; end
        end
      end
      for (int i = 0; i < 4; i++) if (rise[i]) m_pend[i] = 1;
      for (int i = 0; i < 4; i++) m_prev[i] = irq[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [3:0] e_ack,
                           input logic [1:0] e_cause, input logic e_rp, input logic e_mis);
    chk({tag, ".pc_out"}, pc_out, e_pc);
    chk({tag, ".irq_ack"}, 32'(irq_ack), 32'(e_ack));
    chk({tag, ".irq_cause"}, 32'(irq_cause), 32'(e_cause));
    chk({tag, ".redirect_pend"}, 32'(redirect_pend), 32'(e_rp));
    chk({tag, ".misalign_err"}, 32'(misalign_err), 32'(e_mis));
  endtask

  task automatic idle_inputs();
    write_en = 0; pc_in = 0; im_stall = 0; dm_stall = 0; csr_stall = 0;
    csr_ret = 0; csr_retpc = 0; csr_flush = 0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] pc_in;
    logic        stall;
    logic [3:0]  irq;
    logic        ret;
    logic [31:0] retpc;
    logic        flush;
    logic [31:0] e_pc;
    logic [3:0]  e_ack;
    logic [1:0]  e_cause;
    logic        e_rp;
    logic        e_mis;
  } vec_t;

  function automatic vec_t mk(logic we, logic [31:0] pi, logic st, logic [3:0] iq, logic rt,
                              logic [31:0] rp, logic fl, logic [31:0] epc, logic [3:0] eack,
                              logic [1:0] ec, logic erp, logic emis);
    vec_t v;
    v.we = we; v.pc_in = pi; v.stall = st; v.irq = iq; v.ret = rt; v.retpc = rp; v.flush = fl;
    v.e_pc = epc; v.e_ack = eack; v.e_cause = ec; v.e_rp = erp; v.e_mis = emis;
    return v;
  endfunction

  vec_t vecs[18];

  initial begin
    vecs[0]  = mk(1, 32'h100, 0, 4'h0, 0, 0,      0, 32'h100,  4'h0, 0, 0, 0);
    vecs[1]  = mk(1, 32'h102, 0, 4'h0, 0, 0,      0, 32'h100,  4'h0, 0, 0, 1);
    vecs[2]  = mk(0, 0,       0, 4'h0, 0, 0,      0, 32'h100,  4'h0, 0, 0, 0);
    vecs[3]  = mk(0, 0,       0, 4'h4, 0, 0,      0, 32'h100,  4'h0, 0, 0, 0);
    vecs[4]  = mk(0, 0,       0, 4'h4, 0, 0,      0, 32'h8008, 4'h4, 2, 0, 0);
    vecs[5]  = mk(0, 0,       0, 4'h0, 0, 0,      0, 32'h8008, 4'h0, 2, 0, 0);
    vecs[6]  = mk(0, 0,       0, 4'hA, 0, 0,      0, 32'h8008, 4'h0, 2, 0, 0);
    vecs[7]  = mk(0, 0,       0, 4'hA, 0, 0,      0, 32'h8004, 4'h2, 1, 0, 0);
    vecs[8]  = mk(0, 0,       0, 4'hA, 0, 0,      0, 32'h800C, 4'h8, 3, 0, 0);
    vecs[9]  = mk(0, 0,       1, 4'h0, 1, 32'h240, 0, 32'h800C, 4'h0, 3, 1, 0);
    vecs[10] = mk(0, 0,       1, 4'h0, 0, 0,      0, 32'h800C, 4'h0, 3, 1, 0);
    vecs[11] = mk(0, 0,       0, 4'h0, 0, 0,      0, 32'h240,  4'h0, 3, 0, 0);
    vecs[12] = mk(0, 0,       1, 4'h0, 1, 32'h300, 0, 32'h240,  4'h0, 3, 1, 0);
    vecs[13] = mk(0, 0,       1, 4'h0, 0, 0,      1, 32'h0,    4'h0, 3, 0, 0);
    vecs[14] = mk(0, 0,       0, 4'h0, 0, 0,      0, 32'h0,    4'h0, 3, 0, 0);
    vecs[15] = mk(1, 32'h10,  0, 4'h0, 0, 0,      1, 32'h0,    4'h0, 3, 0, 0);
    vecs[16] = mk(1, 32'h20,  1, 4'h0, 0, 0,      0, 32'h0,    4'h0, 3, 0, 0);
    vecs[17] = mk(1, 32'h20,  0, 4'h0, 0, 0,      0, 32'h20,   4'h0, 3, 0, 0);

    idle_inputs();
    reset = 1; irq = 0; irq_mask = 4'hF; csr_tvec_base = 32'h8000;
    write_en = 1; pc_in = 32'h100;

    // Reset held 3 cycles with a pending write: PC stays at the reset vector.
    for (int c = 0; c < 3; c++) begin
      step();
      check_all("reset", 32'h0, 4'h0, 0, 0, 0);
    end
    reset = 0;
    step();
    chk("post_reset.pc_out", pc_out, 32'h100);

    for (int k = 0; k < 18; k++) begin
      write_en = vecs[k].we; pc_in = vecs[k].pc_in; csr_stall = vecs[k].stall;
      irq = vecs[k].irq; csr_ret = vecs[k].ret; csr_retpc = vecs[k].retpc;
      csr_flush = vecs[k].flush;
      step();
      check_all($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_ack, vecs[k].e_cause,
                vecs[k].e_rp, vecs[k].e_mis);
    end
    idle_inputs();

    // Return raised during a 5-cycle data stall is held until the stall drops.
    dm_stall = 1; csr_ret = 1; csr_retpc = 32'h240;
    step();
    check_all("dstall0", 32'h20, 4'h0, 3, 1, 0);
    csr_ret = 0;
    for (int c = 1; c < 5; c++) begin
      step();
      check_all("dstall", 32'h20, 4'h0, 3, 1, 0);
    end
    dm_stall = 0;
    step();
    check_all("dstall_rel", 32'h240, 4'h0, 3, 0, 0);

    // Same-cycle irq and return: return wins, irq taken the following cycle.
    irq = 4'h1;
    step();
    check_all("irqret0", 32'h240, 4'h0, 3, 0, 0);
    csr_ret = 1; csr_retpc = 32'h500;
    step();
    check_all("irqret1", 32'h500, 4'h0, 3, 0, 0);
    csr_ret = 0;
    step();
    check_all("irqret2", 32'h8000, 4'h1, 0, 0, 0);
    irq = 4'h0;

    // Irq arriving while a redirect is buffered waits until after release.
    csr_stall = 1; csr_ret = 1; csr_retpc = 32'h600;
    step();
    check_all("pendirq0", 32'h8000, 4'h0, 0, 1, 0);
    csr_ret = 0; irq = 4'h4;
    step();
    check_all("pendirq1", 32'h8000, 4'h0, 0, 1, 0);
    csr_stall = 0;
    step();
    check_all("pendirq2", 32'h600, 4'h0, 0, 0, 0);
    step();
    check_all("pendirq3", 32'h8008, 4'h4, 2, 0, 0);
    irq = 4'h0;

    // Masking a pending line blocks it without dropping it.
    irq = 4'h1;
    step();
    irq = 4'h0; irq_mask = 4'hE;
    step();
    check_all("mask0", 32'h8008, 4'h0, 2, 0, 0);
    step();
    check_all("mask1", 32'h8008, 4'h0, 2, 0, 0);
    irq_mask = 4'hF;
    step();
    check_all("mask2", 32'h8000, 4'h1, 0, 0, 0);

    // Random phase against the model.
    reset = 1;
    idle_inputs();
    step();
    reset = 0;
    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      write_en  = $urandom_range(0, 1);
      pc_in     = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255));
      im_stall  = ($urandom_range(0, 9) == 0);
      dm_stall  = ($urandom_range(0, 9) == 0);
      csr_stall = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) irq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) irq_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0)
        csr_tvec_base = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF7 : $urandom;
      csr_ret   = ($urandom_range(0, 11) == 0);
      csr_retpc = $urandom;
      csr_flush = ($urandom_range(0, 29) == 0);
      step();
      check_all("rand", m_pc, m_ack, 2'(m_cause), m_pst, m_mis);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
